// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_if
// Brief    : Requester-bank / consumer bundle for the round-robin mux arbiter.
// Revision : 1.0
// ============================================================================
interface mux_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] in;
    logic       out_ready;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       out;
    logic       out_valid;
    logic       busy;

    modport master (
        output req, in, out_ready,
        input  grant, sel, out, out_valid, busy
    );

    modport slave (
        input  req, in, out_ready,
        output grant, sel, out, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : 8:1 round-robin arbiter streaming bounded bursts over valid/ready.
// Revision : 1.0
// ============================================================================
module mux_rr_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int N_REQ     = 8,
    parameter int SEL_W     = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_rr_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0]       c_last_beat = 4'(BURST_MAX - 1);
    localparam logic [N_REQ-1:0] c_one       = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [SEL_W-1:0]  cand;
    logic              rel;

    // Scan starts at ptr and wraps naturally through the SEL_W-bit adder.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_q + SEL_W'(k);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        rel        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d    = c_one << pick_idx;
                    sel_d      = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A dropped request ends the grant without a transfer.
                if (!bus.req[sel_q]) begin
                    rel = 1'b1;
                end else if (bus.out_ready) begin
                    if (beat_cnt_q == c_last_beat) begin
                        rel = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // sel is left holding; the mandatory IDLE bubble re-picks it next.
        if (rel) begin
            ptr_d      = sel_q + SEL_W'(1);
            grant_d    = '0;
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.out       = bus.in[sel_q];
    assign bus.out_valid = (state_q == ST_BUSY) && bus.req[sel_q];
    assign bus.busy      = (state_q == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Brief    : Directed stimulus with a beat scoreboard for mux_rr_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mux_rr_arbiter;

    typedef struct packed {
        logic [2:0] sel;
        logic       bit_v;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;
    beat_t exp_q[$];
    beat_t mon_e;
    logic [7:0] pat;
    logic [7:0] eg;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.BURST_MAX(4), .N_REQ(8), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_beats(input logic [2:0] s, input logic b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{sel: s, bit_v: b});
    endtask

    // Scoreboard: every accepted beat must match the next expected one.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("beat_sel", 32'(bus.sel), 32'(mon_e.sel));
                check("beat_out", 32'(bus.out), 32'(mon_e.bit_v));
                check("beat_grant", 32'(bus.grant), 32'(8'h01 << mon_e.sel));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with all requests high and no clock edge yet.
        rst_n         = 1'b0;
        bus.req       = 8'hFF;
        bus.in        = 8'h01;
        bus.out_ready = 1'b0;
        #2;
        check("rst_grant", 32'(bus.grant), 32'h00);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_in0_hi", 32'(bus.out), 32'd1);
        bus.in = 8'h00;
        #1;
        check("rst_out_in0_lo", 32'(bus.out), 32'd0);
        tick();
        check("rst_hold_grant", 32'(bus.grant), 32'h00);
        rst_n = 1'b1;
        tick();
        check("rst_first_grant", 32'(bus.grant), 32'h01);
        check("rst_first_busy", 32'(bus.busy), 32'd1);
        do_reset();

        // Lone requester 5: four beats, one bubble, re-grant.
        pat           = 8'b1011_0100;
        bus.in        = pat;
        bus.req       = 8'b0010_0000;
        bus.out_ready = 1'b1;
        push_beats(3'd5, 1'b1, 4);
        tick();
        check("single_grant", 32'(bus.grant), 32'h20);
        check("single_sel", 32'(bus.sel), 32'd5);
        check("single_out", 32'(bus.out), 32'd1);
        repeat (3) tick();
        check("single_grant_hold", 32'(bus.grant), 32'h20);
        tick();
        check("single_bubble_grant", 32'(bus.grant), 32'h00);
        check("single_bubble_busy", 32'(bus.busy), 32'd0);
        check("single_bubble_valid", 32'(bus.out_valid), 32'd0);
        check("single_beats_done", 32'(exp_q.size()), 32'd0);
        tick();
        check("single_regrant", 32'(bus.grant), 32'h20);
        bus.out_ready = 1'b0;
        do_reset();

        // Full contention: 0..7 then wrap to 0, five cycles per grant.
        pat           = 8'hA5;
        bus.in        = pat;
        bus.req       = 8'hFF;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) push_beats(3'(k % 8), pat[k % 8], 4);
        for (int k = 0; k < 9; k++) begin
            eg = 8'h01 << (k % 8);
            tick();
            check("rr_grant", 32'(bus.grant), 32'(eg));
            check("rr_sel", 32'(bus.sel), 32'(k % 8));
            repeat (4) tick();
            check("rr_bubble", 32'(bus.grant), 32'h00);
        end
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        check("rr_beats_done", 32'(exp_q.size()), 32'd0);
        do_reset();

        // Backpressure on requester 3 after the first beat.
        bus.in        = 8'h08;
        bus.req       = 8'h08;
        bus.out_ready = 1'b1;
        push_beats(3'd3, 1'b1, 4);
        tick();
        check("bp_grant", 32'(bus.grant), 32'h08);
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_grant_hold", 32'(bus.grant), 32'h08);
            check("bp_beat_cnt", 32'(dut.beat_cnt_q), 32'd1);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_pending", 32'(exp_q.size()), 32'd3);
        end
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("bp_resume_grant", 32'(bus.grant), 32'h08);
        tick();
        check("bp_release", 32'(bus.grant), 32'h00);
        check("bp_beats_done", 32'(exp_q.size()), 32'd0);
        do_reset();

        // Early drop: move ptr to 2, then drop req[2] after two beats.
        bus.in        = 8'b0100_0100;
        bus.req       = 8'b0000_0010;
        bus.out_ready = 1'b0;
        tick();
        check("drop_pre_grant", 32'(bus.grant), 32'h02);
        bus.req = 8'h00;
        tick();
        check("drop_pre_ptr", 32'(dut.ptr_q), 32'd2);
        bus.req       = 8'b0100_0110;
        bus.out_ready = 1'b1;
        push_beats(3'd2, 1'b1, 2);
        tick();
        check("drop_grant2", 32'(bus.grant), 32'h04);
        repeat (2) tick();
        bus.req = 8'b0100_0010;
        tick();
        check("drop_release", 32'(bus.grant), 32'h00);
        check("drop_ptr", 32'(dut.ptr_q), 32'd3);
        tick();
        check("drop_next_grant", 32'(bus.grant), 32'h40);
        check("drop_next_sel", 32'(bus.sel), 32'd6);
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        check("drop_beats_done", 32'(exp_q.size()), 32'd0);
        do_reset();

        // Asynchronous reset in the middle of requester 4's burst.
        bus.in        = 8'h10;
        bus.req       = 8'h10;
        bus.out_ready = 1'b1;
        push_beats(3'd4, 1'b1, 1);
        tick();
        check("mid_grant", 32'(bus.grant), 32'h10);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(bus.grant), 32'h00);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        bus.req = 8'b0001_0010;
        #2;
        rst_n = 1'b1;
        tick();
        check("mid_after_grant", 32'(bus.grant), 32'h02);
        check("mid_after_sel", 32'(bus.sel), 32'd1);
        bus.out_ready = 1'b0;
        check("mid_beats_done", 32'(exp_q.size()), 32'd0);

        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for an 8:1 bit multiplexer shared by 8 requesters.
- Picks one requester, drives the mux select, and streams that requester's data bit to a single consumer over a valid/ready handshake.
- Each grant carries a bounded burst of beats, then arbitration restarts so no requester can starve the others.
- Sits between the requester bank and the downstream consumer.

Parameters:
- BURST_MAX, 4, maximum beats per grant (1..15).
- N_REQ, 8, number of requesters. Fixed at 8.
- SEL_W, 3, select width. Fixed at 3, equal to log2(N_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  per-requester request; held high while it has data.
- in  input  8  per-requester data bit; in[i] belongs to req[i].
- out_ready  input  1  consumer accepts the beat this cycle.
- grant  output  8  one-hot registered grant; all zero when idle.
- sel  output  3  registered mux select, equal to the index of the grant bit.
- out  output  1  in[sel], combinational from registered sel.
- out_valid  output  1  beat is valid.
- busy  output  1  high while in state BUSY.

Behaviour:
- Reset:
  - Asynchronous assert; all state clears immediately, with no clock edge needed.
  - Cleared state: state=IDLE, grant=0, sel=0, ptr=0, beat_cnt=0, busy=0, out_valid=0.
  - out follows in[0] while sel=0.
  - Clean release: the first clock edge after rst_n rises acts as a normal IDLE cycle.
- Internal state: ptr (3-bit round-robin start index) and beat_cnt (4-bit).
- State IDLE:
  - If req != 0: pick the first i with req[i]=1, scanning ptr, ptr+1, ... modulo 8 (7 wraps to 0).
  - Register grant=1<<i and sel=i, clear beat_cnt, go to BUSY.
  - If req == 0: hold IDLE, grant stays 0.
  - Latency: req rises before edge n, grant is visible after edge n.
- State BUSY:
  - out_valid = req[sel] (combinational, from the registered sel). busy=1.
  - A beat transfers when out_valid && out_ready. On a transfer, beat_cnt increments.
- Release from BUSY: at the edge where either condition holds:
  - (a) req[sel]=0 (no transfer occurs that cycle), or
  - (b) a transfer occurs with beat_cnt == BURST_MAX-1.
- On release:
  - ptr = sel+1 mod 8 (sel=7 gives ptr=0).
  - grant=0, beat_cnt=0, go to IDLE.
  - This gives exactly one idle bubble cycle between grants.
- Backpressure: with out_ready=0, beat_cnt, grant and sel hold. out tracks in[sel] live. There is no timeout.
- Invariants: grant is always zero or one-hot, and sel always equals the index of the grant bit.
- Requests arriving or dropping on non-granted lines during BUSY have no effect until the next IDLE cycle.
- A lone requester still releases after BURST_MAX beats, takes the bubble, then is re-granted.
- BURST_MAX=1: every transfer releases.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF and no clock edges -> grant=8'h00, sel=3'b000, out_valid=0, busy=0. Release, then one edge -> grant=8'h01.
- Single requester: in=8'b10110100, req=8'b00100000, out_ready=1 -> grant=8'b00100000, sel=3'b101, out=1 for 4 beats. Then one cycle with grant=0, then re-grant to 5.
- Full contention: req=8'hFF, out_ready=1 -> grant sequence 0,1,2,...,7,0. Each grant lasts 4 beats plus 1 bubble (5 cycles per requester). Wrap 7->0 is checked.
- Backpressure: during a burst on requester 3, after 1 beat drive out_ready=0 for 3 cycles -> grant=8'h08 holds, beat_cnt stays 1, out_valid=1. Resume -> exactly 3 more beats, then release.
- Early drop: requester 2 granted, req[2] drops after 2 beats, req[1] and req[6] pending -> release on that edge with ptr=3. The next grant goes to 6, not 1.
- Reset mid-burst: assert rst_n=0 between clock edges during requester 4's burst -> grant, out_valid and busy clear immediately. After release with req=8'b00010010 -> grant goes to 1 (ptr=0).
